// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the board LED bank: one requester at a time, bounded
// tenure under contention, one idle cycle between owners.

module led_bank_lane #(
  parameter int LED_COUNT = 16
) (
  input  logic                 sel,
  input  logic [LED_COUNT-1:0] data,
  output logic [LED_COUNT-1:0] q
);
  assign q = sel ? data : '0;
endmodule

module led_bank_arbiter #(
  parameter int LED_COUNT = 16,
  parameter int NUM_REQ   = 4,
  parameter int MAX_HOLD  = 1000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LED_COUNT-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic [LED_COUNT-1:0]           led
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [TW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? TW'(MAX_HOLD - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                              state, state_n;
  logic [IW-1:0]                       owner, owner_n, ptr, ptr_n, pick;
  logic [TW-1:0]                       ten, ten_n;
  logic [NUM_REQ-1:0]                  grant_n;
  logic                                busy_n, found, rel, others;
  logic [LED_COUNT-1:0]                led_n, owner_pat;
  logic [NUM_REQ-1:0][LED_COUNT-1:0]   pat, masked;

  assign pat = req_data;

  // grant is one-hot on the owner while in OWN, so it doubles as the data select
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    led_bank_lane #(.LED_COUNT(LED_COUNT)) u_lane (
      .sel  (grant[g]),
      .data (pat[g]),
      .q    (masked[g])
    );
  end

  always_comb begin
    owner_pat = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_pat = owner_pat | masked[i];
  end

  // first set request at or after ptr, wrapping past NUM_REQ-1
  always_comb begin
    logic [IW:0] idx;
    idx   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  assign others = |(req & ~grant);
  assign rel    = !req[owner] ||
                  ((MAX_HOLD != 0) && (ten == HOLD_LAST) && others);

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    ten_n   = ten;
    grant_n = grant;
    led_n   = led;
    case (state)
      IDLE: begin
        if (found) begin
          owner_n = pick;
          grant_n = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          ten_n   = '0;
          state_n = OWN;
        end
      end
      OWN: begin
        if (rel) begin
          // led keeps its last value; no blanking between owners
          grant_n = '0;
          ptr_n   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          state_n = IDLE;
        end else begin
          led_n = owner_pat;
          if ((MAX_HOLD != 0) && (ten != HOLD_LAST)) ten_n = ten + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = |grant_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      ten   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      led   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      ten   <= ten_n;
      grant <= grant_n;
      busy  <= busy_n;
      led   <= led_n;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_busy_match:    assert property (@(posedge clk) disable iff (!rst_n) busy == (|grant));

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Cycle-table bench for led_bank_arbiter (4 requesters, 16 LEDs, hold 8).

module tb_led_bank_arbiter;
  localparam int LC = 16;
  localparam int NR = 4;
  localparam int MH = 8;

  localparam logic [15:0] P0 = 16'h1111;
  localparam logic [15:0] P1 = 16'h00FF;
  localparam logic [15:0] P2 = 16'hA5A5;
  localparam logic [15:0] P3 = 16'h8001;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*LC-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic              busy;
  logic [LC-1:0]     led;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [15:0] led;
  } vec_t;

  typedef struct {
    int          id;
    logic [3:0]  grant;
    logic [15:0] led;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  led_bank_arbiter #(.LED_COUNT(LC), .NUM_REQ(NR), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .busy     (busy),
    .led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [15:0] l, input int n);
    vec_t v;
    v.rst = r; v.req = rq; v.grant = g; v.led = l;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h want %h", name, id, act, exp);
    end
  endtask

  // monitor: one expectation retired per rising edge, sampled just after it
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant", e.id, 32'(grant), 32'(e.grant));
      chk("busy",  e.id, 32'(busy),  32'(|e.grant));
      chk("led",   e.id, 32'(led),   32'(e.led));
    end
  end

  initial begin
    exp_t e;
    rst_n    = 1'b0;
    req      = '0;
    req_data = {P3, P2, P1, P0};

    // reset, then idle with no requests
    add(1, 4'b0000, 4'b0000, 16'h0000, 2);
    add(0, 4'b0000, 4'b0000, 16'h0000, 20);
    // single requester 2, held 10 cycles then dropped
    add(0, 4'b0100, 4'b0100, 16'h0000, 1);
    add(0, 4'b0100, 4'b0100, P2, 9);
    add(0, 4'b0000, 4'b0000, P2, 3);
    // full contention from a fresh ptr
    add(1, 4'b0000, 4'b0000, 16'h0000, 1);
    add(0, 4'b1111, 4'b0001, 16'h0000, 1);
    add(0, 4'b1111, 4'b0001, P0, 7);
    add(0, 4'b1111, 4'b0000, P0, 1);
    add(0, 4'b1111, 4'b0010, P0, 1);
    add(0, 4'b1111, 4'b0010, P1, 7);
    add(0, 4'b1111, 4'b0000, P1, 1);
    add(0, 4'b1111, 4'b0100, P1, 1);
    add(0, 4'b1111, 4'b0100, P2, 7);
    add(0, 4'b1111, 4'b0000, P2, 1);
    add(0, 4'b1111, 4'b1000, P2, 1);
    add(0, 4'b1111, 4'b1000, P3, 7);
    add(0, 4'b1111, 4'b0000, P3, 1);
    add(0, 4'b1111, 4'b0001, P3, 1);
    add(0, 4'b1111, 4'b0001, P0, 1);
    add(0, 4'b0000, 4'b0000, P0, 1);
    // uncontended hold for 50 cycles, then requester 3 arrives
    add(0, 4'b0001, 4'b0001, P0, 50);
    add(0, 4'b1001, 4'b0000, P0, 1);
    add(0, 4'b1001, 4'b1000, P0, 1);
    add(0, 4'b1000, 4'b1000, P3, 3);
    // owner 3 releases with 0 and 2 pending: ptr wraps to 0
    add(0, 4'b0101, 4'b0000, P3, 1);
    add(0, 4'b0101, 4'b0001, P3, 1);
    add(0, 4'b0101, 4'b0001, P0, 1);
    // set up owner 1 for the mid-grant reset
    add(1, 4'b0000, 4'b0000, 16'h0000, 1);
    add(0, 4'b0010, 4'b0010, 16'h0000, 1);
    add(0, 4'b0010, 4'b0010, P1, 2);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = ~vecs[i].rst;
      req   = vecs[i].req;
      e.id = i; e.grant = vecs[i].grant; e.led = vecs[i].led;
      sb.push_back(e);
    end

    // asynchronous reset between edges while requester 1 owns the bank
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 9000, 32'(grant), 32'h0);
    chk("async_rst_busy",  9000, 32'(busy),  32'h0);
    chk("async_rst_led",   9000, 32'(led),   32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0011;
    e.id = 9001; e.grant = 4'b0001; e.led = 16'h0000;
    sb.push_back(e);
    @(negedge clk);
    e.id = 9002; e.grant = 4'b0001; e.led = P0;
    sb.push_back(e);
    @(posedge clk);
    #2;

    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
# led_bank_arbiter

Round-robin arbiter that shares the board LED bank between up to NUM_REQ independent requesters (status counters, debug probes, core heartbeat). Each requester presents a request and a LED pattern. The arbiter grants exactly one owner at a time, enforces a maximum tenure when others are waiting, and drives the registered LED outputs from the current owner. It sits between the LED-producing blocks and the top-level `led` pins.

## Interface
- `LED_COUNT`, default 16: width of the LED bank and of each requester's pattern.
- `NUM_REQ`, default 4: number of requesters, legal range 2..16.
- `MAX_HOLD`, default 1000000: maximum grant cycles while another requester is pending; 0 means no limit.
- `clk`  in  1: single clock domain; all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low; release is synchronous to `clk` externally.
- `req`  in  NUM_REQ: level request, bit i from requester i.
- `req_data`  in  NUM_REQ*LED_COUNT: pattern of requester i at bits [i*LED_COUNT +: LED_COUNT].
- `grant`  out  NUM_REQ: registered, one-hot or zero; bit i means requester i owns the bank.
- `busy`  out  1: registered; high whenever `grant` is nonzero.
- `led`  out  LED_COUNT: registered LED drive.

## Operation
- State machine with two states, IDLE and OWN. Registers:
  - `owner` index.
  - Round-robin pointer `ptr`, reset 0.
  - Tenure counter, width clog2(MAX_HOLD+1).
- Reset values: state IDLE, `grant`=0, `busy`=0, `led`=0, `ptr`=0, tenure=0, `owner`=0.
- IDLE:
  - If `req` is nonzero, select the first set bit searching ptr, ptr+1, … NUM_REQ-1, 0, … (wrap-around).
  - Load `owner`, set that `grant` bit, clear tenure, go to OWN.
  - If `req` is 0, stay in IDLE.
- OWN, each cycle:
  - `led` <= `req_data[owner]`.
  - Tenure increments, saturating at MAX_HOLD-1.
- Release: if `req[owner]`=0, then `grant`<=0, `ptr`<=owner+1 (mod NUM_REQ), go to IDLE. `led` is not updated in this cycle.
- Preempt: if MAX_HOLD≠0, tenure==MAX_HOLD-1, and any other `req` bit is set, release exactly as above, even though `req[owner]` is still high.
- If no other requester is pending, the owner keeps the bank indefinitely. Tenure stays saturated, so a preempt occurs on the first cycle another request appears.
- Break-before-make: every owner change passes through IDLE. `grant` is zero for exactly one cycle between owners.
- `led` holds its last value while IDLE; no blanking.
- MAX_HOLD=1: owner is granted for 1 cycle when contended.
- Requests are levels. A requester that drops `req` while not granted simply loses its place, with no queueing.
- Async reset mid-grant: all outputs return to reset values immediately; no grant survives reset.

## Timing
- Request-to-grant: `req` high before edge N in IDLE gives `grant` high after edge N.
- `led` shows owner data after edge N+1. After that, `led` tracks `req_data[owner]` with 1-cycle latency.
- Release latency: `req[owner]` low before edge M gives `grant`=0 after edge M. The earliest next grant appears after edge M+1.
- Contended tenure: the owner holds `grant` for exactly MAX_HOLD cycles (edges N..N+MAX_HOLD-1). `grant` is 0 after edge N+MAX_HOLD, and the next owner is granted after edge N+MAX_HOLD+1.
- Simultaneous requests arriving with owner release: arbitration happens in the following IDLE cycle using the updated `ptr`.

## Test plan
- Reset and idle (NUM_REQ=4, MAX_HOLD=8): assert `rst_n`=0 mid-run, then hold `req`=0. Required: `grant`=0, `busy`=0, `led`=0 for 20 cycles.
- Single requester:
  - Stimulus: `req`=4'b0100 with `req_data[2]`=16'hA5A5, held 10 cycles, then dropped.
  - Required: `grant`=4'b0100 from the cycle after the request; `led`=16'hA5A5 one cycle later; `grant`=0 one cycle after the drop; `led` stays A5A5.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held, MAX_HOLD=8.
  - Required grant sequence: 0001, 0, 0010, 0, 0100, 0, 1000, 0, 0001. Each owner is granted for exactly 8 cycles, with a 1-cycle gap between owners.
- Uncontended hold: `req`=4'b0001 for 50 cycles, then assert `req[3]`. Required: no preempt before `req[3]`; `grant` drops the next cycle; `grant`=4'b1000 one cycle after that.
- Wrap-around and skip: owner 3 releases while `req`=4'b0101. Required: after a 1-cycle gap, `grant`=4'b0001, because `ptr` wraps to 0.
- Reset mid-grant: assert `rst_n`=0 while `grant`=4'b0010 and `led`=16'h00FF. Required: `grant`=0 and `led`=0 asynchronously. After release with `req`=4'b0011, `grant`=4'b0001, because `ptr` was reset to 0.
